player_r_ctrl: RTL and testbench



---
 rtl/player_r_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_player_r_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_r_ctrl.sv
// player_r_ctrl: once-per-frame motion and attack sequencer for the
// right-hand player sprite; buttons are sampled on each rising vsync edge.
module player_r_ctrl #(
    parameter int START_X     = 100,
    parameter int X_MAX       = 845,
    parameter int WALK_STEP   = 2,
    parameter int JUMP_STEP   = 4,
    parameter int JUMP_FRAMES = 16,
    parameter int LUNGE_STEP  = 4,
    parameter int LUNGE_MAX   = 24,
    parameter int LEG_DIV     = 8,
    parameter int SWORD_MID   = 12,
    parameter int SWORD_HIGH  = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync_in,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    input  logic        btn_attack,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        respawn,
    output logic [11:0] RP_x_pos,
    output logic [11:0] RP_y_pos,
    output logic        change_legs,
    output logic [4:0]  sword_pos,
    output logic [11:0] x_sword_pos,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WALK      = 3'd1,
        S_JUMP_UP   = 3'd2,
        S_JUMP_DOWN = 3'd3,
        S_LUNGE_OUT = 3'd4,
        S_LUNGE_IN  = 3'd5
    } state_e;

    localparam logic [11:0] SX   = 12'(START_X);
    localparam logic [11:0] XMAX = 12'(X_MAX);
    localparam logic [11:0] WS   = 12'(WALK_STEP);
    localparam logic [11:0] JS   = 12'(JUMP_STEP);
    localparam logic [7:0]  JF   = 8'(JUMP_FRAMES);
    localparam logic [11:0] LS   = 12'(LUNGE_STEP);
    localparam logic [11:0] LM   = 12'(LUNGE_MAX);
    localparam logic [7:0]  LDM1 = 8'(LEG_DIV - 1);
    localparam logic [4:0]  SMID = 5'(SWORD_MID);
    localparam logic [4:0]  SHI  = 5'(SWORD_HIGH);

    state_e      state_q, state_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [11:0] xs_q, xs_d;
    logic [4:0]  sw_q, sw_d;
    logic        legs_q, legs_d;
    logic [7:0]  leg_cnt_q, leg_cnt_d;
    logic [7:0]  jcnt_q, jcnt_d;
    logic        vsync_q;
    logic        p_atk_q, p_atk_d;
    logic        p_up_q, p_up_d;
    logic        p_dn_q, p_dn_d;

    logic        tick;
    logic        dir_l, dir_r, dir_nz;
    logic        atk_new, up_new, dn_new;
    logic [11:0] x_mv;
    logic [4:0]  sw_step;

    // Frame tick, direction decode, press edges and the clamped walk step.
    always_comb begin
        tick    = vsync_in & ~vsync_q;
        dir_l   = btn_left & ~btn_right;
        dir_r   = btn_right & ~btn_left;
        dir_nz  = dir_l | dir_r;
        atk_new = btn_attack & ~p_atk_q;
        up_new  = btn_up & ~p_up_q;
        dn_new  = btn_down & ~p_dn_q;
        x_mv    = x_q;
        if (dir_l) begin
            x_mv = (x_q >= XMAX - WS) ? XMAX : x_q + WS;
        end else if (dir_r) begin
            x_mv = (x_q <= WS) ? 12'd0 : x_q - WS;
        end
        sw_step = sw_q;
        unique case (1'b1)
            up_new & ~dn_new: sw_step = (sw_q == 5'd0) ? SMID : SHI;
            dn_new & ~up_new: sw_step = (sw_q == SHI) ? SMID : 5'd0;
            default:          sw_step = sw_q;
        endcase
    end

    // Next-state logic: respawn overrides everything, otherwise act on a tick.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        xs_d      = xs_q;
        sw_d      = sw_q;
        legs_d    = legs_q;
        leg_cnt_d = leg_cnt_q;
        jcnt_d    = jcnt_q;
        p_atk_d   = p_atk_q;
        p_up_d    = p_up_q;
        p_dn_d    = p_dn_q;
        if (respawn) begin
            state_d   = S_IDLE;
            x_d       = SX;
            y_d       = 12'd0;
            xs_d      = 12'd0;
            sw_d      = 5'd0;
            legs_d    = 1'b0;
            leg_cnt_d = 8'd0;
            jcnt_d    = 8'd0;
            p_atk_d   = btn_attack;
            p_up_d    = btn_up;
            p_dn_d    = btn_down;
        end else if (tick) begin
            p_atk_d = btn_attack;
            p_up_d  = btn_up;
            p_dn_d  = btn_down;
            if (state_q != S_LUNGE_OUT && state_q != S_LUNGE_IN) begin
                sw_d = sw_step;
            end
            unique case (state_q)
                S_IDLE, S_WALK: begin
                    legs_d    = 1'b0;
                    leg_cnt_d = 8'd0;
                    if (btn_jump) begin
                        state_d = S_JUMP_UP;
                        jcnt_d  = 8'd0;
                    end else if (atk_new) begin
                        state_d = S_LUNGE_OUT;
                    end else if (dir_nz) begin
                        state_d = S_WALK;
                        x_d     = x_mv;
                        if (leg_cnt_q == LDM1) begin
                            leg_cnt_d = 8'd0;
                            legs_d    = ~legs_q;
                        end else begin
                            leg_cnt_d = leg_cnt_q + 8'd1;
                            legs_d    = legs_q;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_JUMP_UP: begin
                    y_d    = y_q + JS;
                    x_d    = x_mv;
                    jcnt_d = jcnt_q + 8'd1;
                    if (jcnt_q + 8'd1 == JF) begin
                        state_d = S_JUMP_DOWN;
                        jcnt_d  = 8'd0;
                    end
                end
                S_JUMP_DOWN: begin
                    y_d = (y_q > JS) ? y_q - JS : 12'd0;
                    x_d = x_mv;
                    if (y_q <= JS) begin
                        state_d = dir_nz ? S_WALK : S_IDLE;
                    end
                end
                S_LUNGE_OUT: begin
                    xs_d = xs_q + LS;
                    if (xs_q + LS == LM) begin
                        state_d = S_LUNGE_IN;
                    end
                end
                S_LUNGE_IN: begin
                    xs_d = (xs_q > LS) ? xs_q - LS : 12'd0;
                    if (xs_q <= LS) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset aborts any motion in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            x_q       <= SX;
            y_q       <= 12'd0;
            xs_q      <= 12'd0;
            sw_q      <= 5'd0;
            legs_q    <= 1'b0;
            leg_cnt_q <= 8'd0;
            jcnt_q    <= 8'd0;
            vsync_q   <= 1'b0;
            p_atk_q   <= 1'b0;
            p_up_q    <= 1'b0;
            p_dn_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            xs_q      <= xs_d;
            sw_q      <= sw_d;
            legs_q    <= legs_d;
            leg_cnt_q <= leg_cnt_d;
            jcnt_q    <= jcnt_d;
            vsync_q   <= vsync_in;
            p_atk_q   <= p_atk_d;
            p_up_q    <= p_up_d;
            p_dn_q    <= p_dn_d;
        end
    end

    assign RP_x_pos    = x_q;
    assign RP_y_pos    = y_q;
    assign change_legs = legs_q;
    assign sword_pos   = sw_q;
    assign x_sword_pos = xs_q;
    assign state       = state_q;

endmodule

// File: tb/tb_player_r_ctrl.sv
// tb_player_r_ctrl: directed and random frames checked against a
// frame-level behavioural model of the player sequencer.
module tb_player_r_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync_in = 1'b0;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
    logic        btn_attack = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic        respawn = 1'b0;
    logic [11:0] RP_x_pos, RP_y_pos, x_sword_pos;
    logic        change_legs;
    logic [4:0]  sword_pos;
    logic [2:0]  state;

    int checks = 0;
    int failures = 0;

    player_r_ctrl dut (
        .clk(clk), .reset(reset), .vsync_in(vsync_in),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
        .btn_attack(btn_attack), .btn_up(btn_up), .btn_down(btn_down),
        .respawn(respawn), .RP_x_pos(RP_x_pos), .RP_y_pos(RP_y_pos),
        .change_legs(change_legs), .sword_pos(sword_pos),
        .x_sword_pos(x_sword_pos), .state(state)
    );

    always #5 clk = ~clk;

    logic [44:0] dvec;
    always_comb dvec = {RP_x_pos, RP_y_pos, change_legs, sword_pos, x_sword_pos, state};

    // Frame-level model: mode 0 idle,1 walk,2 rise,3 fall,4 lunge out,5 lunge back.
    int mx, my, mxs, msw, mode, rise_frames, walk_frames;
    bit mlegs, pa, pu, pd;

    function automatic void model_home(bit keep_btns);
        mx = 100; my = 0; mxs = 0; msw = 0; mode = 0;
        rise_frames = 0; walk_frames = 0; mlegs = 0;
        pa = keep_btns ? btn_attack : 1'b0;
        pu = keep_btns ? btn_up : 1'b0;
        pd = keep_btns ? btn_down : 1'b0;
    endfunction

    function automatic void model_tick();
        int d;
        bit na, nu, nd;
        d = 0;
        if (btn_left && !btn_right) d = 1;
        if (btn_right && !btn_left) d = -1;
        na = btn_attack && !pa;
        nu = btn_up && !pu;
        nd = btn_down && !pd;
        pa = btn_attack; pu = btn_up; pd = btn_down;
        if (mode < 4) begin
            if (nu && !nd) msw = (msw == 0) ? 12 : 24;
            if (nd && !nu) msw = (msw == 24) ? 12 : 0;
        end
        if (mode <= 1) begin
            if (btn_jump) begin
                mode = 2; rise_frames = 0;
            end else if (na) mode = 4;
            else if (d != 0) begin
                mode = 1; mx = mx + 2 * d;
            end else mode = 0;
            if (mode == 1) begin
                walk_frames++;
                if (walk_frames % 8 == 0) mlegs = ~mlegs;
            end else begin
                walk_frames = 0; mlegs = 0;
            end
        end else if (mode == 2 || mode == 3) begin
            mx = mx + 2 * d;
            if (mode == 2) begin
                rise_frames++;
                my = 4 * rise_frames;
                if (rise_frames == 16) mode = 3;
            end else begin
                my = (my > 4) ? my - 4 : 0;
                if (my == 0) mode = (d != 0) ? 1 : 0;
            end
        end else if (mode == 4) begin
            mxs += 4;
            if (mxs == 24) mode = 5;
        end else begin
            mxs -= 4;
            if (mxs == 0) mode = 0;
        end
        if (mx < 0) mx = 0;
        if (mx > 845) mx = 845;
    endfunction

    function automatic logic [44:0] mvec();
        return {12'(mx), 12'(my), mlegs, 5'(msw), 12'(mxs), 3'(mode)};
    endfunction

    task automatic frame();
        @(negedge clk); vsync_in = 1'b1;
        @(negedge clk); model_tick();
        @(negedge clk); vsync_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic release_all();
        btn_left = 0; btn_right = 0; btn_jump = 0;
        btn_attack = 0; btn_up = 0; btn_down = 0;
    endtask

    task automatic pulse_respawn();
        @(negedge clk); respawn = 1'b1;
        @(negedge clk); respawn = 1'b0;
        model_home(1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        release_all();
        model_home(1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (RP_x_pos !== 12'd100 || RP_y_pos !== 12'd0 || state !== 3'd0) begin
            failures++;
            $display("FAIL reset_pos got x=%0d y=%0d st=%0d want x=100 y=0 st=0", RP_x_pos, RP_y_pos, state);
        end
        checks++;
        if (sword_pos !== 5'd0 || x_sword_pos !== 12'd0 || change_legs !== 1'b0) begin
            failures++;
            $display("FAIL reset_pose got sw=%0d xs=%0d legs=%0b want 0 0 0", sword_pos, x_sword_pos, change_legs);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_walk();
        btn_left = 1;
        for (int i = 1; i <= 10; i++) begin
            frame();
            checks++;
            if (RP_x_pos !== 12'(100 + 2 * i) || change_legs !== (i >= 8) || state !== 3'd1) begin
                failures++;
                $display("FAIL walk tick %0d got x=%0d legs=%0b st=%0d want x=%0d legs=%0b st=1",
                         i, RP_x_pos, change_legs, state, 100 + 2 * i, (i >= 8));
            end
        end
        checks++;
        if (dvec !== mvec()) begin
            failures++;
            $display("FAIL walk_model got %h want %h", dvec, mvec());
        end
    endtask

    task automatic test_clamp();
        btn_left = 1;
        for (int i = 0; i < 1000 && mx < 844; i++) frame();
        checks++;
        if (RP_x_pos !== 12'd844) begin
            failures++;
            $display("FAIL clamp_844 got %0d want 844", RP_x_pos);
        end
        for (int i = 0; i < 2; i++) begin
            frame();
            checks++;
            if (RP_x_pos !== 12'd845) begin
                failures++;
                $display("FAIL clamp_hi %0d got %0d want 845", i, RP_x_pos);
            end
        end
        btn_left = 0; btn_right = 1;
        for (int i = 0; i < 1000 && mx > 1; i++) frame();
        checks++;
        if (RP_x_pos !== 12'd1) begin
            failures++;
            $display("FAIL clamp_1 got %0d want 1", RP_x_pos);
        end
        for (int i = 0; i < 2; i++) begin
            frame();
            checks++;
            if (RP_x_pos !== 12'd0) begin
                failures++;
                $display("FAIL clamp_lo %0d got %0d want 0", i, RP_x_pos);
            end
        end
        checks++;
        if (dvec !== mvec()) begin
            failures++;
            $display("FAIL clamp_model got %h want %h", dvec, mvec());
        end
    endtask

    task automatic test_jump();
        release_all();
        frame();
        btn_jump = 1;
        frame();
        btn_jump = 0;
        checks++;
        if (state !== 3'd2 || RP_y_pos !== 12'd0) begin
            failures++;
            $display("FAIL jump_start got st=%0d y=%0d want st=2 y=0", state, RP_y_pos);
        end
        for (int i = 1; i <= 32; i++) begin
            frame();
            checks++;
            if (RP_y_pos !== 12'((i <= 16) ? 4 * i : 128 - 4 * i)) begin
                failures++;
                $display("FAIL jump_y tick %0d got %0d want %0d", i, RP_y_pos, (i <= 16) ? 4 * i : 128 - 4 * i);
            end
        end
        checks++;
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL jump_land got st=%0d want 0", state);
        end
        pulse_respawn();
        btn_left = 1; btn_jump = 1;
        frame();
        btn_jump = 0;
        for (int i = 1; i <= 32; i++) begin
            frame();
            checks++;
            if (RP_x_pos !== 12'(100 + 2 * i)) begin
                failures++;
                $display("FAIL jump_x tick %0d got %0d want %0d", i, RP_x_pos, 100 + 2 * i);
            end
        end
        checks++;
        if (state !== 3'd1 || dvec !== mvec()) begin
            failures++;
            $display("FAIL jump_walk_land got %h want %h (st 1)", dvec, mvec());
        end
    endtask

    task automatic test_lunge();
        int x0;
        release_all();
        frame();
        btn_left = 1; btn_attack = 1;
        frame();
        x0 = 100 + 64;
        checks++;
        if (state !== 3'd4 || x_sword_pos !== 12'd0 || RP_x_pos !== 12'(x0)) begin
            failures++;
            $display("FAIL lunge_start got st=%0d xs=%0d x=%0d want 4 0 %0d", state, x_sword_pos, RP_x_pos, x0);
        end
        for (int i = 1; i <= 12; i++) begin
            frame();
            checks++;
            if (x_sword_pos !== 12'((i <= 6) ? 4 * i : 48 - 4 * i) || RP_x_pos !== 12'(x0)) begin
                failures++;
                $display("FAIL lunge tick %0d got xs=%0d x=%0d want xs=%0d x=%0d",
                         i, x_sword_pos, RP_x_pos, (i <= 6) ? 4 * i : 48 - 4 * i, x0);
            end
        end
        checks++;
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL lunge_end got st=%0d want 0", state);
        end
        frame();
        checks++;
        if (state !== 3'd1 || x_sword_pos !== 12'd0) begin
            failures++;
            $display("FAIL lunge_held got st=%0d xs=%0d want st=1 xs=0", state, x_sword_pos);
        end
        btn_attack = 0; btn_left = 0;
        frame();
        btn_attack = 1;
        frame();
        checks++;
        if (state !== 3'd4) begin
            failures++;
            $display("FAIL lunge_repress got st=%0d want 4", state);
        end
        btn_attack = 0;
        repeat (12) frame();
        checks++;
        if (dvec !== mvec() || state !== 3'd0) begin
            failures++;
            $display("FAIL lunge_model got %h want %h", dvec, mvec());
        end
    endtask

    task automatic test_guard();
        release_all();
        frame();
        btn_jump = 1; btn_attack = 1;
        frame();
        btn_jump = 0; btn_attack = 0;
        checks++;
        if (state !== 3'd2 || x_sword_pos !== 12'd0) begin
            failures++;
            $display("FAIL guard_prio got st=%0d xs=%0d want 2 0", state, x_sword_pos);
        end
        for (int k = 1; k <= 3; k++) begin
            btn_up = 1;
            frame();
            checks++;
            if (sword_pos !== 5'((k == 1) ? 12 : 24)) begin
                failures++;
                $display("FAIL guard_up %0d got %0d want %0d", k, sword_pos, (k == 1) ? 12 : 24);
            end
            btn_up = 0;
            frame();
        end
        btn_up = 1; btn_down = 1;
        frame();
        checks++;
        if (sword_pos !== 5'd24) begin
            failures++;
            $display("FAIL guard_both got %0d want 24", sword_pos);
        end
        btn_up = 0; btn_down = 0;
        frame();
        btn_down = 1;
        frame();
        checks++;
        if (sword_pos !== 5'd12) begin
            failures++;
            $display("FAIL guard_down got %0d want 12", sword_pos);
        end
        btn_down = 0;
        for (int i = 0; i < 40 && mode != 0; i++) frame();
        checks++;
        if (dvec !== mvec()) begin
            failures++;
            $display("FAIL guard_model got %h want %h", dvec, mvec());
        end
    endtask

    task automatic test_respawn();
        release_all();
        frame();
        btn_attack = 1;
        repeat (3) frame();
        pulse_respawn();
        checks++;
        if (RP_x_pos !== 12'd100 || RP_y_pos !== 12'd0 || x_sword_pos !== 12'd0 || state !== 3'd0) begin
            failures++;
            $display("FAIL respawn_lunge got x=%0d y=%0d xs=%0d st=%0d want 100 0 0 0",
                     RP_x_pos, RP_y_pos, x_sword_pos, state);
        end
        frame();
        checks++;
        if (state !== 3'd0 || x_sword_pos !== 12'd0) begin
            failures++;
            $display("FAIL respawn_held got st=%0d xs=%0d want 0 0", state, x_sword_pos);
        end
        btn_attack = 0; btn_jump = 1; btn_left = 1;
        frame();
        btn_jump = 0;
        repeat (3) frame();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (RP_x_pos !== 12'd100 || RP_y_pos !== 12'd0 || state !== 3'd0 || sword_pos !== 5'd0) begin
            failures++;
            $display("FAIL async_reset got x=%0d y=%0d st=%0d sw=%0d want 100 0 0 0",
                     RP_x_pos, RP_y_pos, state, sword_pos);
        end
        @(negedge clk);
        reset = 1'b0;
        release_all();
        model_home(1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 400; f++) begin
            btn_left   = ($urandom_range(0, 2) != 0);
            btn_right  = ($urandom_range(0, 2) == 0);
            btn_jump   = ($urandom_range(0, 9) == 0);
            btn_attack = ($urandom_range(0, 3) == 0);
            btn_up     = ($urandom_range(0, 3) == 0);
            btn_down   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) pulse_respawn();
            frame();
            checks++;
            if (dvec !== mvec()) begin
                failures++;
                $display("FAIL random frame %0d got %h want %h", f, dvec, mvec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_clamp();
        test_jump();
        test_lunge();
        test_guard();
        test_respawn();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
